// File: rtl/tlb_pkg.sv
// Shared constants and types for the TLB associative memory.
// Default geometry matches the legacy 32-entry, 20-bit-key TLB.
package tlb_pkg;

    localparam int unsigned TLB_ENTRIES     = 32;
    localparam int unsigned TLB_KEY_WIDTH   = 20;
    localparam int unsigned TLB_VALUE_WIDTH = 20;
    localparam int unsigned TLB_WIRED       = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } tlb_state_e;

    typedef struct packed {
        logic [TLB_KEY_WIDTH-1:0]   key;
        logic [TLB_VALUE_WIDTH-1:0] value;
    } tlb_entry_t;

endpackage

// File: rtl/tlb_priority_encoder.sv
// Lowest-index priority encoder: reports whether any bit is set and the
// position of the lowest set bit (0 when none).
module tlb_priority_encoder #(
    parameter int unsigned ENTRIES     = 32,
    parameter int unsigned INDEX_WIDTH = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]     match_i,
    output logic                   any_o,
    output logic [INDEX_WIDTH-1:0] index_o
);

    always_comb begin
        any_o   = |match_i;
        index_o = '0;
        // Scan high to low so the last assignment is the lowest set bit.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                index_o = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_cam.sv
// Registered TLB associative memory: key/value entries with valid bits,
// one-cycle lookup and read, random replacement index and invalidate-all.
// Optional multiHit output is built when TLB_CAM_MULTI_HIT_DETECT_EN is defined.
module tlb_cam
    import tlb_pkg::*;
#(
    parameter int unsigned ENTRIES     = TLB_ENTRIES,
    parameter int unsigned KEY_WIDTH   = TLB_KEY_WIDTH,
    parameter int unsigned VALUE_WIDTH = TLB_VALUE_WIDTH,
    parameter int unsigned WIRED       = TLB_WIRED,
    parameter int unsigned INDEX_WIDTH = $clog2(ENTRIES)
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   lookupValid,
    input  logic [KEY_WIDTH-1:0]   lookupKey,
    output logic                   lookupDone,
    output logic                   lookupHit,
    output logic [INDEX_WIDTH-1:0] lookupIndex,
    output logic [VALUE_WIDTH-1:0] lookupValue,
    input  logic [INDEX_WIDTH-1:0] accessIndex,
    input  logic                   accessRead,
    output logic                   readDone,
    output logic [KEY_WIDTH-1:0]   readKey,
    output logic [VALUE_WIDTH-1:0] readValue,
    output logic                   readEntryValid,
    input  logic                   writeEnable,
    input  logic                   writeRandom,
    input  logic [KEY_WIDTH-1:0]   writeKey,
    input  logic [VALUE_WIDTH-1:0] writeValue,
    output logic [INDEX_WIDTH-1:0] randomIndex,
    input  logic                   flushStart,
    output logic                   busy
`ifdef TLB_CAM_MULTI_HIT_DETECT_EN
    ,
    output logic                   multiHit
`endif
);

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } entry_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX  = INDEX_WIDTH'(ENTRIES - 1);
    localparam logic [INDEX_WIDTH-1:0] WIRED_INDEX = INDEX_WIDTH'(WIRED);
    localparam logic [INDEX_WIDTH-1:0] INDEX_ONE   = INDEX_WIDTH'(1);

    entry_t                 mem_q [ENTRIES];
    logic [ENTRIES-1:0]     valid_q, valid_d;
    tlb_state_e             state_q, state_d;
    logic [INDEX_WIDTH-1:0] flush_ptr_q, flush_ptr_d;
    logic [INDEX_WIDTH-1:0] rand_q, rand_d;

    logic                   lookup_done_q, lookup_done_d;
    logic                   lookup_hit_q, lookup_hit_d;
    logic [INDEX_WIDTH-1:0] lookup_index_q, lookup_index_d;
    logic [VALUE_WIDTH-1:0] lookup_value_q, lookup_value_d;
    logic                   read_done_q, read_done_d;
    logic [KEY_WIDTH-1:0]   read_key_q, read_key_d;
    logic [VALUE_WIDTH-1:0] read_value_q, read_value_d;
    logic                   read_valid_q, read_valid_d;

    logic [ENTRIES-1:0]     match;
    logic                   lk_any;
    logic [INDEX_WIDTH-1:0] lk_idx;
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_idx;

    // Matches are suppressed while flushing so lookups complete as misses.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid_q[i] && (mem_q[i].key == lookupKey) && (state_q == IDLE);
        end
    end

    tlb_priority_encoder #(
        .ENTRIES    (ENTRIES),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_lookup_enc (
        .match_i(match),
        .any_o  (lk_any),
        .index_o(lk_idx)
    );

    assign wr_en  = writeEnable && (state_q == IDLE);
    assign wr_idx = writeRandom ? rand_q : accessIndex;

    always_comb begin
        state_d     = state_q;
        flush_ptr_d = flush_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (flushStart) begin
                    state_d     = FLUSH;
                    flush_ptr_d = '0;
                end
            end
            FLUSH: begin
                flush_ptr_d = flush_ptr_q + INDEX_ONE;
                if (flush_ptr_q == LAST_INDEX) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (state_q == FLUSH) begin
            valid_d[flush_ptr_q] = 1'b0;
        end else if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    // Counter cycles ENTRIES-1 down to WIRED, never touching wired entries.
    always_comb begin
        if (rand_q == WIRED_INDEX) begin
            rand_d = LAST_INDEX;
        end else begin
            rand_d = rand_q - INDEX_ONE;
        end
    end

    always_comb begin
        lookup_done_d  = lookupValid;
        lookup_hit_d   = lookupValid && lk_any;
        lookup_index_d = '0;
        lookup_value_d = '0;
        if (lookupValid && lk_any) begin
            lookup_index_d = lk_idx;
            lookup_value_d = mem_q[lk_idx].value;
        end
    end

    always_comb begin
        read_done_d  = accessRead;
        read_key_d   = '0;
        read_value_d = '0;
        read_valid_d = 1'b0;
        if (accessRead) begin
            read_key_d   = mem_q[accessIndex].key;
            read_value_d = mem_q[accessIndex].value;
            read_valid_d = valid_q[accessIndex];
        end
    end

    // Entry storage is intentionally not reset; valid bits gate its use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= '{key: writeKey, value: writeValue};
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_q        <= '0;
            state_q        <= IDLE;
            flush_ptr_q    <= '0;
            rand_q         <= LAST_INDEX;
            lookup_done_q  <= 1'b0;
            lookup_hit_q   <= 1'b0;
            lookup_index_q <= '0;
            lookup_value_q <= '0;
            read_done_q    <= 1'b0;
            read_key_q     <= '0;
            read_value_q   <= '0;
            read_valid_q   <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            state_q        <= state_d;
            flush_ptr_q    <= flush_ptr_d;
            rand_q         <= rand_d;
            lookup_done_q  <= lookup_done_d;
            lookup_hit_q   <= lookup_hit_d;
            lookup_index_q <= lookup_index_d;
            lookup_value_q <= lookup_value_d;
            read_done_q    <= read_done_d;
            read_key_q     <= read_key_d;
            read_value_q   <= read_value_d;
            read_valid_q   <= read_valid_d;
        end
    end

`ifdef TLB_CAM_MULTI_HIT_DETECT_EN
    localparam logic [ENTRIES-1:0] ONE_HOT0 = {{(ENTRIES - 1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0]     match_rest;
    logic                   rest_any;
    logic [INDEX_WIDTH-1:0] rest_idx;
    logic                   multi_hit_q;

    // Remove the winning match; anything left means a second hit.
    always_comb begin
        match_rest = match;
        if (lk_any) begin
            match_rest = match & ~(ONE_HOT0 << lk_idx);
        end
    end

    tlb_priority_encoder #(
        .ENTRIES    (ENTRIES),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_multi_enc (
        .match_i(match_rest),
        .any_o  (rest_any),
        .index_o(rest_idx)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            multi_hit_q <= 1'b0;
        end else begin
            multi_hit_q <= lookupValid && rest_any && (rest_idx != lk_idx);
        end
    end

    assign multiHit = multi_hit_q;
`endif

    assign lookupDone     = lookup_done_q;
    assign lookupHit      = lookup_hit_q;
    assign lookupIndex    = lookup_index_q;
    assign lookupValue    = lookup_value_q;
    assign readDone       = read_done_q;
    assign readKey        = read_key_q;
    assign readValue      = read_value_q;
    assign readEntryValid = read_valid_q;
    assign randomIndex    = rand_q;
    assign busy           = (state_q == FLUSH);

endmodule

// File: tb/tb_tlb_cam.sv
// Self-checking bench for tlb_cam against an array-based reference model.
module tb_tlb_cam;
    import tlb_pkg::*;

    localparam int E     = TLB_ENTRIES;
    localparam int KW    = TLB_KEY_WIDTH;
    localparam int VW    = TLB_VALUE_WIDTH;
    localparam int WIRED = TLB_WIRED;
    localparam int IW    = $clog2(E);

    logic          clock, resetN;
    logic          lookupValid;
    logic [KW-1:0] lookupKey;
    logic          lookupDone, lookupHit;
    logic [IW-1:0] lookupIndex;
    logic [VW-1:0] lookupValue;
    logic [IW-1:0] accessIndex;
    logic          accessRead;
    logic          readDone;
    logic [KW-1:0] readKey;
    logic [VW-1:0] readValue;
    logic          readEntryValid;
    logic          writeEnable, writeRandom;
    logic [KW-1:0] writeKey;
    logic [VW-1:0] writeValue;
    logic [IW-1:0] randomIndex;
    logic          flushStart, busy;
    logic          multiHit;

    tlb_cam dut (
        .clock         (clock),
        .resetN        (resetN),
        .lookupValid   (lookupValid),
        .lookupKey     (lookupKey),
        .lookupDone    (lookupDone),
        .lookupHit     (lookupHit),
        .lookupIndex   (lookupIndex),
        .lookupValue   (lookupValue),
        .accessIndex   (accessIndex),
        .accessRead    (accessRead),
        .readDone      (readDone),
        .readKey       (readKey),
        .readValue     (readValue),
        .readEntryValid(readEntryValid),
        .writeEnable   (writeEnable),
        .writeRandom   (writeRandom),
        .writeKey      (writeKey),
        .writeValue    (writeValue),
        .randomIndex   (randomIndex),
        .flushStart    (flushStart),
        .busy          (busy)
`ifdef TLB_CAM_MULTI_HIT_DETECT_EN
        ,
        .multiHit      (multiHit)
`endif
    );

`ifndef TLB_CAM_MULTI_HIT_DETECT_EN
    assign multiHit = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks;
    int failures;

    // Reference model
    tlb_entry_t m_mem [E];
    bit         m_valid [E];
    bit         m_written [E];
    int         m_rand;
    int         m_flush_cnt;

    bit            exp_done, exp_hit, exp_multi;
    logic [IW-1:0] exp_idx;
    logic [VW-1:0] exp_val;
    bit            exp_rdone, exp_rvalid, exp_rknown;
    logic [KW-1:0] exp_rkey;
    logic [VW-1:0] exp_rval;

    task automatic drive_idle();
        lookupValid = 0; lookupKey = '0; accessIndex = '0; accessRead = 0;
        writeEnable = 0; writeRandom = 0; writeKey = '0; writeValue = '0; flushStart = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < E; i++) m_valid[i] = 0;
        m_rand      = E - 1;
        m_flush_cnt = 0;
    endtask

    // Forms expectations from pre-edge model state, clocks once, then advances the model.
    task automatic tick();
        int n;
        int widx;
        bit do_wr, do_fl;
        n         = 0;
        exp_done  = lookupValid;
        exp_hit   = 0;
        exp_idx   = '0;
        exp_val   = '0;
        if (lookupValid && m_flush_cnt == 0) begin
            for (int i = 0; i < E; i++) begin
                if (m_valid[i] && m_mem[i].key == lookupKey) begin
                    if (n == 0) begin
                        exp_hit = 1;
                        exp_idx = IW'(i);
                        exp_val = m_mem[i].value;
                    end
                    n++;
                end
            end
        end
        exp_multi  = (n > 1);
        exp_rdone  = accessRead;
        exp_rkey   = m_mem[accessIndex].key;
        exp_rval   = m_mem[accessIndex].value;
        exp_rvalid = m_valid[accessIndex];
        exp_rknown = m_written[accessIndex];
        widx  = writeRandom ? m_rand : int'(accessIndex);
        do_wr = writeEnable && m_flush_cnt == 0;
        do_fl = flushStart && m_flush_cnt == 0;
        @(posedge clock);
        #1;
        if (m_flush_cnt > 0) begin
            m_valid[E - m_flush_cnt] = 0;
            m_flush_cnt--;
        end else if (do_fl) begin
            m_flush_cnt = E;
        end
        if (do_wr) begin
            m_mem[widx].key   = writeKey;
            m_mem[widx].value = writeValue;
            m_valid[widx]     = 1;
            m_written[widx]   = 1;
        end
        m_rand = (m_rand == WIRED) ? E - 1 : m_rand - 1;
    endtask

    task automatic apply_reset();
        resetN = 0;
        model_reset();
        #1;
        @(posedge clock);
        #1;
        resetN = 1;
    endtask

    task automatic write_entry(input int idx, input logic [KW-1:0] k, input logic [VW-1:0] v);
        writeEnable = 1; writeRandom = 0; accessIndex = IW'(idx); writeKey = k; writeValue = v;
        tick();
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        resetN = 0;
        model_reset();
        for (int i = 0; i < E; i++) m_written[i] = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({lookupDone, lookupHit, readDone, readEntryValid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {lookupDone, lookupHit, readDone, readEntryValid, busy});
        end
        checks++;
        if (lookupIndex !== '0 || lookupValue !== '0 || readKey !== '0 || readValue !== '0) begin
            failures++;
            $display("FAIL reset_data: idx=%0d val=%h rkey=%h rval=%h expected all 0",
                     lookupIndex, lookupValue, readKey, readValue);
        end
        resetN = 1;
        checks++;
        if (randomIndex !== IW'(E - 1)) begin
            failures++;
            $display("FAIL reset_random: got %0d expected %0d", randomIndex, E - 1);
        end
    endtask

    task automatic test_random_counter();
        for (int c = 0; c < 60; c++) begin
            tick();
            checks++;
            if (randomIndex !== IW'(m_rand) || int'(randomIndex) < WIRED) begin
                failures++;
                $display("FAIL random_seq[%0d]: got %0d expected %0d", c, randomIndex, m_rand);
            end
        end
    endtask

    task automatic test_lookup_hit();
        write_entry(5, 20'h12345, 20'($urandom));
        write_entry(3, 20'h44444, 20'($urandom));
        write_entry(7, 20'h44444, 20'($urandom));
        lookupValid = 1; lookupKey = 20'h44444;
        tick();
        drive_idle();
        checks++;
        if (lookupDone !== 1'b1 || lookupHit !== 1'b1 || lookupIndex !== 5'd3 ||
            lookupValue !== m_mem[3].value) begin
            failures++;
            $display("FAIL lookup_hit: done=%b hit=%b idx=%0d val=%h expected 1 1 3 %h",
                     lookupDone, lookupHit, lookupIndex, lookupValue, m_mem[3].value);
        end
`ifdef TLB_CAM_MULTI_HIT_DETECT_EN
        checks++;
        if (multiHit !== 1'b1) begin
            failures++;
            $display("FAIL multi_hit: got %b expected 1", multiHit);
        end
`endif
        tick();
        checks++;
        if (lookupDone !== 1'b0) begin
            failures++;
            $display("FAIL lookup_pulse: done=%b expected 0", lookupDone);
        end
    endtask

    task automatic test_lookup_miss();
        lookupValid = 1; lookupKey = 20'h12121;
        tick();
        drive_idle();
        checks++;
        if (lookupDone !== 1'b1 || lookupHit !== 1'b0 || lookupIndex !== '0 ||
            lookupValue !== '0) begin
            failures++;
            $display("FAIL lookup_miss: done=%b hit=%b idx=%0d val=%h expected 1 0 0 0",
                     lookupDone, lookupHit, lookupIndex, lookupValue);
        end
    endtask

    task automatic test_back_to_back();
        lookupValid = 1; lookupKey = 20'h44444;
        tick();
        lookupKey = 20'h12345;
        tick();
        checks++;
        if (lookupDone !== 1'b1 || lookupHit !== 1'b1 || lookupIndex !== 5'd5 ||
            lookupValue !== m_mem[5].value) begin
            failures++;
            $display("FAIL b2b_lookup: done=%b hit=%b idx=%0d val=%h expected 1 1 5 %h",
                     lookupDone, lookupHit, lookupIndex, lookupValue, m_mem[5].value);
        end
        lookupKey = 20'h44444; accessRead = 1; accessIndex = 5'd7;
        tick();
        drive_idle();
        checks++;
        if (lookupIndex !== 5'd3 || readDone !== 1'b1 || readKey !== 20'h44444 ||
            readEntryValid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_concurrent: idx=%0d rdone=%b rkey=%h rvalid=%b expected 3 1 44444 1",
                     lookupIndex, readDone, readKey, readEntryValid);
        end
    endtask

    task automatic test_read_write_same_cycle();
        writeEnable = 1; accessIndex = 5'd6; writeKey = 20'h91919; writeValue = 20'hABCDE;
        accessRead  = 1;
        tick();
        drive_idle();
        checks++;
        if (readDone !== 1'b1 || readEntryValid !== 1'b0 || readKey === 20'h91919) begin
            failures++;
            $display("FAIL rw_same_cycle: rdone=%b rvalid=%b rkey=%h expected 1 0 old-key",
                     readDone, readEntryValid, readKey);
        end
        accessRead = 1; accessIndex = 5'd6;
        tick();
        drive_idle();
        checks++;
        if (readKey !== 20'h91919 || readValue !== 20'hABCDE || readEntryValid !== 1'b1) begin
            failures++;
            $display("FAIL read_after_write: key=%h val=%h valid=%b expected 91919 abcde 1",
                     readKey, readValue, readEntryValid);
        end
    endtask

    task automatic test_flush();
        int busy_cycles;
        flushStart = 1;
        tick();
        drive_idle();
        busy_cycles = 0;
        for (int g = 0; g < 40 && busy === 1'b1; g++) begin
            busy_cycles++;
            if (g == 2) begin
                lookupValid = 1; lookupKey = 20'h44444; accessRead = 1; accessIndex = 5'd7;
            end
            if (g == 10) begin
                writeEnable = 1; accessIndex = 5'd2; writeKey = 20'h12345; writeValue = 20'h1;
                flushStart  = 1;
            end
            tick();
            if (g == 2) begin
                checks++;
                if (lookupDone !== 1'b1 || lookupHit !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_lookup: done=%b hit=%b expected 1 0", lookupDone, lookupHit);
                end
                checks++;
                if (readEntryValid !== exp_rvalid || readKey !== exp_rkey) begin
                    failures++;
                    $display("FAIL flush_read: valid=%b key=%h expected %b %h",
                             readEntryValid, readKey, exp_rvalid, exp_rkey);
                end
            end
            drive_idle();
        end
        checks++;
        if (busy_cycles != E || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_len: got %0d cycles busy=%b expected %0d cycles busy=0",
                     busy_cycles, busy, E);
        end
        lookupValid = 1; lookupKey = 20'h12345;
        tick();
        checks++;
        if (lookupHit !== 1'b0) begin
            failures++;
            $display("FAIL flush_miss_12345: hit=%b idx=%0d expected 0", lookupHit, lookupIndex);
        end
        lookupKey = 20'h44444;
        tick();
        drive_idle();
        checks++;
        if (lookupHit !== 1'b0) begin
            failures++;
            $display("FAIL flush_miss_44444: hit=%b idx=%0d expected 0", lookupHit, lookupIndex);
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [IW-1:0] ridx;
        write_entry(9, 20'h77777, 20'h2);
        write_entry(20, 20'h88888, 20'h3);
        flushStart = 1;
        tick();
        drive_idle();
        repeat (10) tick();
        resetN = 0;
        model_reset();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flush_busy: got %b expected 0", busy);
        end
        @(posedge clock);
        #1;
        resetN = 1;
        for (int i = 0; i < E; i++) begin
            accessRead = 1; accessIndex = IW'(i);
            tick();
            checks++;
            if (readDone !== 1'b1 || readEntryValid !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_valid[%0d]: done=%b valid=%b expected 1 0",
                         i, readDone, readEntryValid);
            end
        end
        drive_idle();
        ridx = IW'(m_rand);
        writeEnable = 1; writeRandom = 1; accessIndex = 5'd0;
        writeKey = 20'hCAFE5; writeValue = 20'h5A5A5;
        tick();
        drive_idle();
        lookupValid = 1; lookupKey = 20'hCAFE5;
        tick();
        drive_idle();
        checks++;
        if (lookupHit !== 1'b1 || lookupIndex !== ridx || lookupValue !== 20'h5A5A5) begin
            failures++;
            $display("FAIL random_write: hit=%b idx=%0d val=%h expected 1 %0d 5a5a5",
                     lookupHit, lookupIndex, lookupValue, ridx);
        end
    endtask

    task automatic test_random_traffic();
        for (int c = 0; c < 400; c++) begin
            lookupValid = 1'($urandom);
            lookupKey   = 20'h50000 | 20'($urandom_range(0, 7));
            accessRead  = 1'($urandom);
            accessIndex = IW'($urandom);
            writeEnable = ($urandom_range(0, 2) == 0);
            writeRandom = 1'($urandom);
            writeKey    = 20'h50000 | 20'($urandom_range(0, 7));
            writeValue  = 20'($urandom);
            flushStart  = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (lookupDone !== exp_done || (exp_done && (lookupHit !== exp_hit ||
                lookupIndex !== exp_idx || lookupValue !== exp_val))) begin
                failures++;
                $display("FAIL rand_lookup[%0d]: done=%b hit=%b idx=%0d val=%h expected %b %b %0d %h",
                         c, lookupDone, lookupHit, lookupIndex, lookupValue,
                         exp_done, exp_hit, exp_idx, exp_val);
            end
`ifdef TLB_CAM_MULTI_HIT_DETECT_EN
            checks++;
            if (exp_done && multiHit !== exp_multi) begin
                failures++;
                $display("FAIL rand_multi[%0d]: got %b expected %b", c, multiHit, exp_multi);
            end
`endif
            checks++;
            if (readDone !== exp_rdone || (exp_rdone && (readEntryValid !== exp_rvalid ||
                (exp_rknown && (readKey !== exp_rkey || readValue !== exp_rval))))) begin
                failures++;
                $display("FAIL rand_read[%0d]: done=%b valid=%b key=%h val=%h expected %b %b %h %h",
                         c, readDone, readEntryValid, readKey, readValue,
                         exp_rdone, exp_rvalid, exp_rkey, exp_rval);
            end
            checks++;
            if (busy !== (m_flush_cnt > 0) || randomIndex !== IW'(m_rand)) begin
                failures++;
                $display("FAIL rand_state[%0d]: busy=%b rand=%0d expected %b %0d",
                         c, busy, randomIndex, m_flush_cnt > 0, m_rand);
            end
        end
        drive_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_random_counter();
        test_lookup_hit();
        test_lookup_miss();
        test_back_to_back();
        test_read_write_same_cycle();
        test_flush();
        test_reset_mid_flush();
        apply_reset();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tlb_cam.md
Name: tlb_cam

Overview:
- Parametrised, registered TLB associative memory; successor to the 32x20-bit key-only TLB key memory.
- Stores key/value pairs with per-entry valid bits.
- Provides a one-cycle-latency associative lookup (lowest matching index wins), indexed read/write, a hardware random-replacement index and a multi-cycle invalidate-all sequencer.
- Sits between the CPU MMU stage and the TLB control registers.

Parameters:
ENTRIES, 32, number of TLB entries (power of two, >= 4)
KEY_WIDTH, 20, virtual page number width
VALUE_WIDTH, 20, page frame plus flag bits width
WIRED, 4, lowest index the random counter may produce (0 <= WIRED < ENTRIES-1)
INDEX_WIDTH, $clog2(ENTRIES), derived; never overridden

Ports:
clock  in  1  system clock, all state on rising edge
resetN  in  1  asynchronous active-low reset
lookupValid  in  1  start lookup this cycle
lookupKey  in  KEY_WIDTH  key to search
lookupDone  out  1  registered; high one cycle after lookupValid
lookupHit  out  1  valid with lookupDone
lookupIndex  out  INDEX_WIDTH  lowest matching index; 0 on miss
lookupValue  out  VALUE_WIDTH  value of matched entry; 0 on miss
accessIndex  in  INDEX_WIDTH  index for read/write
accessRead  in  1  read entry at accessIndex
readDone  out  1  registered; high one cycle after accessRead
readKey  out  KEY_WIDTH  key of entry
readValue  out  VALUE_WIDTH  value of entry
readEntryValid  out  1  valid bit of entry
writeEnable  in  1  write entry, set its valid bit
writeRandom  in  1  with writeEnable: use randomIndex, not accessIndex
writeKey  in  KEY_WIDTH  key to write
writeValue  in  VALUE_WIDTH  value to write
randomIndex  out  INDEX_WIDTH  current replacement index
flushStart  in  1  start invalidate-all
busy  out  1  flush in progress

Behaviour:
- Reset, asynchronous on resetN low: all valid bits 0; randomIndex = ENTRIES-1; FSM = IDLE; all outputs 0. Key/value arrays are not reset.
- Lookup:
  - Sampled on the edge where lookupValid=1. Results registered; lookupDone pulses exactly one cycle.
  - A hit requires valid[i] && key[i]==lookupKey. Multiple hits resolve to the lowest i.
  - A lookup sees array contents before any write in the same cycle (read-before-write).
- Read: same timing as lookup. Returns pre-write contents when accessIndex equals the write index in the same cycle.
- Write: on the edge with writeEnable=1, entry[idx] <= {writeKey, writeValue} and valid[idx] <= 1, where idx = writeRandom ? randomIndex : accessIndex.
- Random counter:
  - Decrements every cycle.
  - When equal to WIRED, the next value is ENTRIES-1.
  - Never enters [0, WIRED-1].
  - Not affected by writes.
- FSM IDLE/FLUSH:
  - IDLE -> FLUSH on flushStart: busy=1 and flush pointer = 0 from the next cycle.
  - FLUSH clears valid[pointer] and increments the pointer each cycle.
  - After clearing ENTRIES-1: FLUSH -> IDLE, busy=0. busy is high for exactly ENTRIES cycles.
- During FLUSH:
  - writeEnable and flushStart are ignored.
  - Lookups complete normally with lookupHit=0.
  - Reads return stored key/value with the current valid bit.
- Reset mid-flush: the FSM returns to IDLE immediately and all valid bits are cleared.
- Simultaneous lookupValid and accessRead are both serviced in the same cycle.

Optional Feature:
- Macro: TLB_CAM_MULTI_HIT_DETECT_EN.
- Defined: extra output port multiHit (1 bit), registered with lookupDone. It is high when more than one valid entry matched; lookupHit/lookupIndex still report the lowest matching index.
- Undefined: the port and its comparison-popcount logic are absent; all other behaviour is identical.

Decomposition:
- Package tlb_pkg holds:
  - default constants TLB_ENTRIES, TLB_KEY_WIDTH, TLB_VALUE_WIDTH, TLB_WIRED;
  - the FSM state enum (IDLE, FLUSH);
  - the entry struct typedef {key, value}.
- One sub-module: tlb_priority_encoder. It is parametrised on ENTRIES and maps the match vector to {any, lowest index}. It is reused for the multi-hit check.

Test Plan:
- Reset, then check randomIndex values from the cycle after reset release: 31, 30, ..., 4, 31 (ENTRIES=32, WIRED=4); never below 4.
- Write key 20'h12345 at index 5 and 20'h44444 at indices 3 and 7, then look up 20'h44444 -> one cycle later lookupHit=1, lookupIndex=3, value of entry 3. With the macro defined, multiHit=1.
- Look up 20'h12121 -> lookupHit=0, lookupIndex=0, lookupValue=0.
- Write index 6 {20'h91919, 20'hABCDE} while reading index 6 in the same cycle -> readKey returns old data and readEntryValid=0. The next read returns 20'h91919, 20'hABCDE, valid=1.
- Start a flush after the writes -> busy high for exactly 32 cycles. A writeEnable mid-flush has no effect. After the flush, lookups of 20'h12345 and 20'h44444 miss.
- Assert resetN=0 at flush cycle 10 -> busy=0 at once. After release all entries read readEntryValid=0. A write with writeRandom=1 lands at the current randomIndex and the next lookup of that key hits that index.
